main_mem_dumper: RTL and testbench

MAIN_MEM_DUMPER -- requirements
Module: main_mem_dumper

---
 rtl/main_mem_dumper.sv | 159 +++++++++++++++
 tb/tb_main_mem_dumper.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/main_mem_dumper.sv
// main_mem_dumper: after the CPU signals terminate, reads every MainMemory word
// once and streams it out as valid/ready beats tagged with its word address.
// Optional feature macro: DUMP_CHECKSUM_EN appends a modulo-2^32 sum beat.
`default_nettype none

module main_mem_dumper #(
  parameter int DEPTH_WORDS = 512,
  parameter int ADDR_W      = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              terminate,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 32'sd1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_mem_ren;
  logic              r_out_valid;
  logic [31:0]       r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;
  logic              w_xfer;

`ifdef DUMP_CHECKSUM_EN
  logic [31:0]       r_sum;
  logic              r_csum_phase;
`endif

  // A beat moves only while the FSM is presenting it and downstream accepts
  assign w_xfer = (r_state == EMIT) && out_ready;

  // Next-state decode; terminate matters only in IDLE and DONE is terminal
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: begin
        if (terminate) w_state_nx = REQ;
        else           w_state_nx = IDLE;
      end
      REQ:  w_state_nx = WAIT;
      WAIT: w_state_nx = EMIT;
      EMIT: begin
        if (w_xfer) begin
`ifdef DUMP_CHECKSUM_EN
          if (r_csum_phase)              w_state_nx = DONE;
          else if (r_cnt == LAST_ADDR)   w_state_nx = EMIT;
          else                           w_state_nx = REQ;
`else
          if (r_cnt == LAST_ADDR) w_state_nx = DONE;
          else                    w_state_nx = REQ;
`endif
        end else begin
          w_state_nx = EMIT;
        end
      end
      DONE:    w_state_nx = DONE;
      default: w_state_nx = IDLE;
    endcase
  end

  // State, counter, payload and status registers; status flags are decoded
  // from the next state so every output comes straight from a flop
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mem_ren   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_sum        <= 32'd0;
      r_csum_phase <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_mem_ren   <= (w_state_nx == REQ);
      r_out_valid <= (w_state_nx == EMIT);
      r_busy      <= (w_state_nx == REQ) || (w_state_nx == WAIT) || (w_state_nx == EMIT);
      r_done      <= (w_state_nx == DONE);
      case (r_state)
        IDLE: begin
          if (terminate) r_cnt <= '0;
        end
        WAIT: begin
          // Read data arrives exactly one cycle after the REQ-cycle enable
          r_out_data <= mem_rdata;
          r_out_addr <= r_cnt;
`ifdef DUMP_CHECKSUM_EN
          r_out_last <= 1'b0;
`else
          r_out_last <= (r_cnt == LAST_ADDR);
`endif
        end
        EMIT: begin
          if (w_xfer) begin
`ifdef DUMP_CHECKSUM_EN
            if (!r_csum_phase) begin
              r_sum <= r_sum + r_out_data;
              if (r_cnt == LAST_ADDR) begin
                // Final memory beat accepted: present the sum as the closing beat
                r_out_data   <= r_sum + r_out_data;
                r_out_addr   <= '0;
                r_out_last   <= 1'b1;
                r_csum_phase <= 1'b1;
              end else begin
                r_cnt <= r_cnt + ONE_ADDR;
              end
            end
`else
            // Counter stops at the last address rather than wrapping
            if (r_cnt != LAST_ADDR) r_cnt <= r_cnt + ONE_ADDR;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_ren   = r_mem_ren;
  assign mem_raddr = r_cnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_main_mem_dumper.sv
// Scoreboard bench for main_mem_dumper with a 4-word memory model.
module tb_main_mem_dumper;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          terminate = 1'b0;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [31:0] mem [DEPTH];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] addr;
    logic          last;
    int            t;
  } beat_t;
  beat_t exp_q[$];

  main_mem_dumper #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .terminate(terminate),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Cycle counter
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: data one cycle after the read enable
  always @(posedge CLK) if (mem_ren) mem_rdata <= mem[mem_raddr];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected beats of a dump whose terminate was sampled just before cycle c0
  task automatic push_dump(input int c0, input int stall, input int nb);
    beat_t b;
    logic [31:0] sum;
    sum = 32'd0;
    for (int k = 0; k < nb; k++) begin
      if (k < DEPTH) begin
        b.data = mem[k];
        b.addr = AW'(k);
        b.last = !CS && (k == DEPTH - 1);
        b.t    = c0 + 2 + 3 * k + ((k >= 1) ? stall : 0);
        sum    = sum + mem[k];
      end else begin
        b.data = sum;
        b.addr = '0;
        b.last = 1'b1;
        b.t    = c0 + 2 + 3 * (DEPTH - 1) + 1 + stall;
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1; RESET = 1'b1;
    @(posedge CLK); #1; RESET = 1'b0;
  endtask

  task automatic dump(input int stall, input bit do_reset, input bit hold_term);
    int c0, rel, nb;
    bit fin;
    @(posedge CLK); #1;
    terminate = 1'b1;
    c0 = cyc + 1;
    nb = do_reset ? 2 : DEPTH + (CS ? 1 : 0);
    push_dump(c0, stall, nb);
    fin = 1'b0;
    for (int i = 0; i < 80 && !fin; i++) begin
      @(posedge CLK); #1;
      rel = cyc - c0;
      if (rel == 0 && !hold_term) terminate = 1'b0;
      if (stall > 0 && rel == 5) out_ready = 1'b0;
      if (stall > 0 && rel == 5 + stall) out_ready = 1'b1;
      if (do_reset && rel == 8) RESET = 1'b1;
      if (do_reset && rel == 9) RESET = 1'b0;
      @(negedge CLK);
      if (stall > 0 && rel >= 5 && rel < 5 + stall)
        check("stall_hold", {29'd0, out_valid, mem_ren, out_data[31:0], AW'(out_addr)},
              {29'd0, 1'b1, 1'b0, mem[1], AW'(1)});
      if (do_reset && rel == 9) begin
        check("reset_mid_dump", {out_valid, out_last, mem_ren, busy, done, out_data, out_addr, mem_raddr},
              64'd0);
        check("reset_queue_drained", 64'(exp_q.size()), 64'd0);
        fin = 1'b1;
      end else if (!do_reset && done) begin
        check("done_status", {61'd0, busy, out_valid, mem_ren}, 64'd0);
        check("done_time", 64'(rel), 64'(12 + stall + (CS ? 1 : 0)));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        fin = 1'b1;
      end
    end
    if (!fin) begin
      miscompares++;
      vectors++;
      $display("FAIL dump_timeout: got no completion want done within 80 cycles");
    end
    if (hold_term) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge CLK);
        check("hold_term_after_done", {61'd0, mem_ren, out_valid, done}, 64'd1);
      end
      @(posedge CLK); #1; terminate = 1'b0;
    end
  endtask

  task automatic run_tests();
    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_values", {out_valid, out_last, mem_ren, busy, done, out_data, out_addr, mem_raddr}, 64'd0);
    @(posedge CLK); #1; RESET = 1'b0;

    // terminate coincident with RESET is ignored
    @(posedge CLK); #1; RESET = 1'b1; terminate = 1'b1;
    @(posedge CLK); #1; RESET = 1'b0; terminate = 1'b0;
    @(negedge CLK);
    check("term_during_reset", {61'd0, busy, mem_ren, out_valid}, 64'd0);
    repeat (2) @(negedge CLK);
    check("term_during_reset_idle", {62'd0, busy, done}, 64'd0);

    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    dump(0, 1'b0, 1'b0);   // basic dump
    pulse_reset();
    dump(5, 1'b0, 1'b0);   // backpressure on beat 1
    pulse_reset();
    dump(0, 1'b1, 1'b0);   // reset in EMIT of beat 2
    dump(0, 1'b0, 1'b1);   // restart from addr 0, terminate held through and after
    pulse_reset();

    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd1; mem[2] = 32'd2; mem[3] = 32'd3;
    dump(0, 1'b0, 1'b0);   // sum wraps to 5 when the checksum beat is present
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge CLK);
          if (!RESET && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_beat: got data %h addr %0d want no beat", out_data, out_addr);
            end else begin
              beat_t e;
              e = exp_q.pop_front();
              check("beat", {out_data, 22'd0, out_addr, out_last, 7'(cyc)},
                    {e.data, 22'd0, e.addr, e.last, 7'(e.t)});
            end
          end
        end
      end
      run_tests();
    join_any
    disable fork;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
